// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle instruction sequencer in front of an external 4-bit ALU.
// Each instruction is accepted in IDLE, decoded (source registers read),
// optionally executed on the external ALU, and written back. R0 reads as
// zero and ignores writes.
//
// Instruction word INSTR[9:0] = {OP[3:0], RD[1:0], RS[1:0], RT[1:0]}
//   ALU ops : 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND
//   1111    : LI  R[RD] <= {RS,RT}
//   others  : illegal (ERR pulse, no side effects)
//
// Ports
//   CLK, RSTN        clock (rising edge), asynchronous active-low reset
//   IV / IR          instruction valid / ready; transfer when both are high
//   INSTR[9:0]       instruction word, sampled on the transfer edge
//   ALU_OP/A/B[3:0]  operands to the external ALU, non-zero only in EXEC
//   ALU_R/Z/O        combinational ALU result, zero and overflow flags
//   DONE             one-cycle pulse in the writeback cycle of a legal op
//   ERR              one-cycle pulse in the writeback cycle of an illegal op
//   FLAG_Z/FLAG_O    registered status flags
//   DBG_SEL/DBG_DATA combinational register-file read port
//
// Timing (handshake edge = edge 0)
//   ALU op  : DECODE, EXEC, WB(DONE=1); register/flag update on edge 3
//   LI/ill. : DECODE, WB(DONE/ERR=1);   register update on edge 2
// -----------------------------------------------------------------------------
module alu_sequencer (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       IV,
  output logic       IR,
  input  logic [9:0] INSTR,
  output logic [3:0] ALU_OP,
  output logic [3:0] ALU_A,
  output logic [3:0] ALU_B,
  input  logic [3:0] ALU_R,
  input  logic       ALU_Z,
  input  logic       ALU_O,
  output logic       DONE,
  output logic       ERR,
  output logic       FLAG_Z,
  output logic       FLAG_O,
  input  logic [1:0] DBG_SEL,
  output logic [3:0] DBG_DATA
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_LI   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    K_ALU,
    K_LI,
    K_ILL
  } kind_t;

  state_t      state;
  kind_t       kind;
  logic [9:0]  instr_q;
  logic [3:0]  res_q;
  logic        z_q;
  logic        o_q;
  logic [3:0]  rf [4];

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [1:0]  rt;

  assign op = instr_q[9:6];
  assign rd = instr_q[5:4];
  assign rs = instr_q[3:2];
  assign rt = instr_q[1:0];

  function automatic logic is_alu_op(input logic [3:0] code);
    case (code)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // Ready is a pure decode of the state register, so it is high as soon as
  // reset forces IDLE without waiting for a clock.
  assign IR       = (state == S_IDLE);
  // rf[0] is reset to zero and never written, so R0 reads as zero for free.
  assign DBG_DATA = rf[DBG_SEL];

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  // NOTE: the register file is only four flops wide and must read zero after
  // reset, so it sits in the reset branch like any other register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= S_IDLE;
      kind    <= K_ILL;
      instr_q <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      o_q     <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      FLAG_Z  <= 1'b0;
      FLAG_O  <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      ALU_OP  <= '0;
      ALU_A   <= '0;
      ALU_B   <= '0;
    end else begin
      // Pulses default low; they are raised only on the edge entering WB.
      DONE <= 1'b0;
      ERR  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (IV) begin
            instr_q <= INSTR;
            state   <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_alu_op(op)) begin
            // Operands are loaded straight into the ALU-facing registers;
            // they double as the latched A/B for the EXEC cycle.
            kind   <= K_ALU;
            ALU_OP <= op;
            ALU_A  <= rf[rs];
            ALU_B  <= rf[rt];
            state  <= S_EXEC;
          end else if (op == OP_LI) begin
            kind  <= K_LI;
            DONE  <= 1'b1;
            state <= S_WB;
          end else begin
            kind  <= K_ILL;
            ERR   <= 1'b1;
            state <= S_WB;
          end
        end

        S_EXEC: begin
          res_q  <= ALU_R;
          z_q    <= ALU_Z;
          o_q    <= ALU_O;
          ALU_OP <= '0;
          ALU_A  <= '0;
          ALU_B  <= '0;
          DONE   <= 1'b1;
          state  <= S_WB;
        end

        S_WB: begin
          case (kind)
            K_ALU: begin
              if (rd != 2'd0) rf[rd] <= res_q;
              FLAG_Z <= z_q;
              // Only arithmetic ops define overflow; logic ops keep the old flag.
              if (op == OP_ADD || op == OP_SUB) FLAG_O <= o_q;
            end
            K_LI: begin
              if (rd != 2'd0) rf[rd] <= {rs, rt};
            end
            default: ;
          endcase
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. The bench supplies the external ALU,
// keeps a transaction-level model (register array, flags and the cycle numbers
// at which each accepted instruction must pulse, drive the ALU and retire),
// and compares every DUT output against it once per cycle on the falling edge.
// Directed sequences pin the model with hand-computed literals; a randomized
// phase and an IV-always-high phase follow.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       IV;
  logic       IR;
  logic [9:0] INSTR;
  logic [3:0] ALU_OP, ALU_A, ALU_B;
  logic [3:0] ALU_R;
  logic       ALU_Z, ALU_O;
  logic       DONE, ERR, FLAG_Z, FLAG_O;
  logic [1:0] DBG_SEL;
  logic [3:0] DBG_DATA;

  logic       junk_o;  // ALU_O value presented for ops that define no overflow

  alu_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .IV(IV), .IR(IR), .INSTR(INSTR),
    .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_R(ALU_R), .ALU_Z(ALU_Z), .ALU_O(ALU_O),
    .DONE(DONE), .ERR(ERR), .FLAG_Z(FLAG_Z), .FLAG_O(FLAG_O),
    .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  // ---------------- external ALU ----------------
  always_comb begin
    ALU_R = 4'd0;
    ALU_O = junk_o;
    case (ALU_OP)
      4'b0000: ALU_R = ALU_A & ALU_B;
      4'b0001: ALU_R = ALU_A | ALU_B;
      4'b0010: begin
        ALU_R = ALU_A + ALU_B;
        ALU_O = (ALU_A[3] == ALU_B[3]) && (ALU_R[3] != ALU_A[3]);
      end
      4'b0110: begin
        ALU_R = ALU_A - ALU_B;
        ALU_O = (ALU_A[3] != ALU_B[3]) && (ALU_R[3] != ALU_A[3]);
      end
      4'b0111: ALU_R = ($signed(ALU_A) < $signed(ALU_B)) ? 4'd1 : 4'd0;
      4'b1100: ALU_R = ~(ALU_A | ALU_B);
      4'b1101: ALU_R = ~(ALU_A & ALU_B);
      default: ALU_R = 4'd0;
    endcase
    ALU_Z = (ALU_R == 4'd0);
  end

  // ---------------- counters and check tasks ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_rf [4];
  logic       m_fz, m_fo;
  int         k;            // index of the current cycle (posedges seen)
  int         idle_at;      // first cycle in which the DUT is ready again
  int         done_cyc;     // cycle carrying the DONE/ERR pulse
  int         exec_cyc;     // cycle in which ALU operands are presented
  int         hs_cyc;       // cycle starting right after the latest handshake
  bit         p_pending, p_ill, p_write, p_wz, p_wo, p_z, p_o;
  logic [1:0] p_rd;
  logic [3:0] p_val, e_op, e_a, e_b;
  int         pulse_cyc;
  bit         pulse_err;
  int         hs_count;

  function automatic bit legal_alu(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD};
  endfunction

  function automatic logic [9:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                    input logic [1:0] rs, input logic [1:0] rt);
    return {op, rd, rs, rt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
    m_fz = 1'b0; m_fo = 1'b0;
    idle_at = k; done_cyc = -10; exec_cyc = -10;
    p_pending = 0; p_ill = 0;
  endtask

  // Instruction accepted on the edge that started cycle k.
  task automatic model_accept(input logic [9:0] ins);
    logic [3:0] op, a, b;
    int sa, sb, sr;
    op = ins[9:6];
    a  = m_rf[ins[3:2]];
    b  = m_rf[ins[1:0]];
    hs_cyc = k; hs_count++;
    p_pending = 1; p_rd = ins[5:4]; p_ill = 0; p_write = 0; p_wz = 0; p_wo = 0;
    if (legal_alu(op)) begin
      sa = $signed(a); sb = $signed(b);
      case (op)
        4'h0: p_val = a & b;
        4'h1: p_val = a | b;
        4'h2: p_val = 4'(int'(a) + int'(b));
        4'h6: p_val = 4'(int'(a) - int'(b));
        4'h7: p_val = (sa < sb) ? 4'd1 : 4'd0;
        4'hC: p_val = ~(a | b);
        default: p_val = ~(a & b);
      endcase
      // Signed overflow: true result outside -8..7.
      sr = (op == 4'h2) ? sa + sb : sa - sb;
      p_write = 1; p_wz = 1; p_z = (p_val == 4'd0);
      p_wo = (op == 4'h2 || op == 4'h6); p_o = (sr > 7 || sr < -8);
      e_op = op; e_a = a; e_b = b;
      exec_cyc = k + 1; done_cyc = k + 2; idle_at = k + 3;
    end else begin
      if (op == 4'hF) begin
        p_write = 1; p_val = ins[3:0];
      end else begin
        p_ill = 1;
      end
      done_cyc = k + 1; idle_at = k + 2;
    end
  endtask

  task automatic model_retire();
    if (p_write && p_rd != 2'd0) m_rf[p_rd] = p_val;
    if (p_wz) m_fz = p_z;
    if (p_wo) m_fo = p_o;
    p_pending = 0;
  endtask

  task automatic compare_outputs();
    bit in_exec;
    in_exec = (k == exec_cyc);
    check1("ir", IR, k >= idle_at);
    check1("done", DONE, (k == done_cyc) && !p_ill);
    check1("err", ERR, (k == done_cyc) && p_ill);
    check("alu_op", ALU_OP, in_exec ? e_op : 4'd0);
    check("alu_a", ALU_A, in_exec ? e_a : 4'd0);
    check("alu_b", ALU_B, in_exec ? e_b : 4'd0);
    check1("flag_z", FLAG_Z, m_fz);
    check1("flag_o", FLAG_O, m_fo);
    check("dbg_data", DBG_DATA, m_rf[DBG_SEL]);
  endtask

  // One clock period: drive at the falling edge, model the rising edge,
  // compare at the next falling edge.
  task automatic run_cycle(input logic iv, input logic [9:0] ins);
    bit accept;
    IV = iv; INSTR = ins; DBG_SEL = 2'($urandom); junk_o = 1'($urandom);
    accept = iv && RSTN && (k >= idle_at);
    @(posedge CLK);
    k++;
    if (accept) model_accept(ins);
    @(negedge CLK);
    if (p_pending && k == idle_at) model_retire();
    compare_outputs();
    if (DONE === 1'b1 || ERR === 1'b1) begin
      pulse_cyc = k; pulse_err = ERR;
    end
  endtask

  // Issue one instruction from idle and run until the DUT is ready again;
  // lat is the hand-computed DONE/ERR latency counted in edges from handshake.
  task automatic issue(input logic [9:0] ins, input int lat, input bit is_err);
    int n;
    pulse_cyc = -100;
    run_cycle(1'b1, ins);
    n = 0;
    while (k < idle_at && n < 8) begin
      run_cycle(1'b0, 10'($urandom));
      n++;
    end
    check("latency", 4'(pulse_cyc - hs_cyc + 1), 4'(lat));
    check1("pulse_kind", pulse_err, is_err);
  endtask

  task automatic peek(input string name, input logic [1:0] sel, input logic [3:0] exp);
    DBG_SEL = sel;
    #1;
    check(name, DBG_DATA, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    k = 0; hs_count = 0; pulse_cyc = -100; pulse_err = 0;
    RSTN = 1'b0; IV = 1'b0; INSTR = '0; DBG_SEL = '0; junk_o = 1'b0;
    model_reset();
    #1;
    check1("rst_ir", IR, 1'b1);
    check1("rst_done", DONE, 1'b0);
    check1("rst_err", ERR, 1'b0);
    check1("rst_fz", FLAG_Z, 1'b0);
    check1("rst_fo", FLAG_O, 1'b0);
    check("rst_alu_op", ALU_OP, 4'd0);
    for (int i = 0; i < 4; i++) peek("rst_rf", 2'(i), 4'd0);

    @(negedge CLK);
    RSTN = 1'b1;
    model_reset();

    // LI / ADD sequence
    issue(mk(4'hF, 2'd1, 2'b01, 2'b01), 2, 1'b0);
    peek("li_r1", 2'd1, 4'b0101);
    issue(mk(4'hF, 2'd2, 2'b00, 2'b01), 2, 1'b0);
    peek("li_r2", 2'd2, 4'b0001);
    issue(mk(4'h2, 2'd3, 2'd1, 2'd2), 3, 1'b0);
    peek("add_r3", 2'd3, 4'b0110);
    check1("add_fz", FLAG_Z, 1'b0);
    check1("add_fo", FLAG_O, 1'b0);

    // ADD overflow, then AND keeps FLAG_O
    issue(mk(4'hF, 2'd1, 2'b01, 2'b11), 2, 1'b0);
    issue(mk(4'h2, 2'd3, 2'd1, 2'd2), 3, 1'b0);
    peek("ovf_r3", 2'd3, 4'b1000);
    check1("ovf_fo", FLAG_O, 1'b1);
    issue(mk(4'h0, 2'd3, 2'd1, 2'd2), 3, 1'b0);
    peek("and_r3", 2'd3, 4'b0001);
    check1("and_fo_held", FLAG_O, 1'b1);

    // SLT, SUB to zero, write to R0
    issue(mk(4'hF, 2'd1, 2'b00, 2'b01), 2, 1'b0);
    issue(mk(4'hF, 2'd2, 2'b00, 2'b11), 2, 1'b0);
    issue(mk(4'h7, 2'd3, 2'd1, 2'd2), 3, 1'b0);
    peek("slt_r3", 2'd3, 4'b0001);
    issue(mk(4'h6, 2'd3, 2'd1, 2'd1), 3, 1'b0);
    peek("sub_r3", 2'd3, 4'b0000);
    check1("sub_fz", FLAG_Z, 1'b1);
    issue(mk(4'h1, 2'd0, 2'd1, 2'd2), 3, 1'b0);
    peek("r0_zero", 2'd0, 4'b0000);
    check1("r0_fz", FLAG_Z, 1'b0);

    // Illegal op: ERR after 2 edges, nothing changes
    issue(mk(4'h3, 2'd1, 2'b11, 2'b11), 2, 1'b1);
    peek("ill_r1", 2'd1, 4'b0001);
    peek("ill_r2", 2'd2, 4'b0011);
    peek("ill_r3", 2'd3, 4'b0000);
    check1("ill_fz", FLAG_Z, 1'b0);
    check1("ill_ir", IR, 1'b1);

    // Reset during EXEC of ADD R1 = R2 + R3
    issue(mk(4'hF, 2'd3, 2'b01, 2'b00), 2, 1'b0);
    run_cycle(1'b1, mk(4'h2, 2'd1, 2'd2, 2'd3));   // DECODE
    run_cycle(1'b0, 10'($urandom));               // EXEC
    #2 RSTN = 1'b0;
    #1;
    check1("mid_rst_ir", IR, 1'b1);
    check1("mid_rst_done", DONE, 1'b0);
    check("mid_rst_alu_a", ALU_A, 4'd0);
    model_reset();
    pulse_cyc = -100;
    run_cycle(1'b0, 10'($urandom));
    run_cycle(1'b0, 10'($urandom));
    check1("rst_no_pulse", pulse_cyc == -100, 1'b1);
    RSTN = 1'b1;
    peek("rst_r1", 2'd1, 4'b0000);
    // Accepted on the first edge after reset release
    issue(mk(4'hF, 2'd1, 2'b10, 2'b10), 2, 1'b0);
    peek("post_rst_r1", 2'd1, 4'b1010);

    // IV held high with INSTR changing every cycle
    hs_count = 0;
    for (int i = 0; i < 120; i++) run_cycle(1'b1, 10'($urandom));
    check1("iv_high_hs", hs_count >= 30 && hs_count <= 40, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      run_cycle($urandom_range(0, 3) != 0, 10'($urandom));
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 10'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
